// File: rtl/float_pkg.sv
// rtl/float_pkg.sv - shared float32 types and constants for the accumulator datapath
package float_pkg;

    localparam int FP32_EXP_W = 8;
    localparam int FP32_MAN_W = 23;
    localparam int FP32_BIAS = 127;
    localparam logic [FP32_EXP_W-1:0] FP32_EXP_MAX = 8'hFF;

    typedef struct packed {
        logic                  sign;
        logic [FP32_EXP_W-1:0] exp;
        logic [FP32_MAN_W-1:0] man;
    } fp32_t;

    localparam fp32_t FP32_POS_ZERO = 32'h0000_0000;
    localparam fp32_t FP32_POS_INF  = 32'h7F80_0000;

    typedef enum logic {
        ACC  = 1'b0,
        DONE = 1'b1
    } acc_state_t;

endpackage

// File: rtl/float_add_core.sv
// rtl/float_add_core.sv - combinational float32 adder: flush-to-zero, RNE rounding, saturating overflow
module float_add_core
    import float_pkg::*;
(
    input  fp32_t a,
    input  fp32_t b,
    output fp32_t sum,
    output logic  overflow
);

    logic              a_zero, b_zero, swap, sub, s_big, s_small, found, round_up;
    logic [7:0]        ea, eb, e_big, e_small, diff;
    logic [23:0]       ma, mb, m_big, m_small;
    logic [26:0]       m_big27, m_small27, aligned, norm;
    logic [27:0]       raw;
    logic [4:0]        lzc;
    logic [24:0]       rounded;
    logic [22:0]       man_fin;
    logic signed [9:0] e_norm, e_fin;

    always_comb begin
        sum      = FP32_POS_ZERO;
        overflow = 1'b0;

        // exp==0 (subnormal) and exp==255 (inf/nan) both contribute zero
        a_zero = (a.exp == 8'd0) || (a.exp == FP32_EXP_MAX);
        b_zero = (b.exp == 8'd0) || (b.exp == FP32_EXP_MAX);
        ea = a_zero ? 8'd0 : a.exp;
        eb = b_zero ? 8'd0 : b.exp;
        ma = a_zero ? 24'd0 : {1'b1, a.man};
        mb = b_zero ? 24'd0 : {1'b1, b.man};

        swap    = {eb, mb} > {ea, ma};
        e_big   = swap ? eb : ea;
        e_small = swap ? ea : eb;
        m_big   = swap ? mb : ma;
        m_small = swap ? ma : mb;
        s_big   = swap ? b.sign : a.sign;
        s_small = swap ? a.sign : b.sign;
        diff    = e_big - e_small;

        // 27-bit working mantissa: hidden bit, 23 fraction bits, guard, round, sticky
        m_big27   = {m_big, 3'b000};
        m_small27 = {m_small, 3'b000};
        if (diff >= 8'd27)
            aligned = {26'd0, |m_small};
        else
            aligned = (m_small27 >> diff)
                    | {26'd0, |(m_small27 & ((27'd1 << diff) - 27'd1))};

        sub = s_big ^ s_small;
        raw = sub ? ({1'b0, m_big27} - {1'b0, aligned})
                  : ({1'b0, m_big27} + {1'b0, aligned});

        lzc   = 5'd0;
        found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!found && raw[i]) begin
                lzc   = 5'(26 - i);
                found = 1'b1;
            end
        end

        if (raw[27]) begin
            norm   = {raw[27:2], raw[1] | raw[0]};
            e_norm = 10'(e_big) + 10'sd1;
        end else begin
            norm   = raw[26:0] << lzc;
            e_norm = 10'(e_big) - 10'(lzc);
        end

        round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
        rounded  = {1'b0, norm[26:3]} + 25'(round_up);
        if (rounded[24]) begin
            e_fin   = e_norm + 10'sd1;
            man_fin = rounded[23:1];
        end else begin
            e_fin   = e_norm;
            man_fin = rounded[22:0];
        end

        if (raw == 28'd0) begin
            sum = FP32_POS_ZERO;
        end else if (e_fin >= 10'sd255) begin
            sum      = '{sign: s_big, exp: FP32_EXP_MAX, man: 23'd0};
            overflow = 1'b1;
        end else if (e_fin <= 10'sd0) begin
            sum = FP32_POS_ZERO;
        end else begin
            sum = '{sign: s_big, exp: e_fin[7:0], man: man_fin};
        end
    end

endmodule

// File: rtl/float_accumulator.sv
// rtl/float_accumulator.sv - sums IN_DEPTH float32 beats per group with sticky exception/overflow flags
module float_accumulator
    import float_pkg::*;
#(
    parameter int IN_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_in_0,
    input  logic        data_in_0_exception,
    input  logic        data_in_0_valid,
    output logic        data_in_0_ready,
    output logic [31:0] data_out_0,
    output logic        data_out_0_exception,
    output logic        data_out_0_overflow,
    output logic        data_out_0_valid,
    input  logic        data_out_0_ready
);

    localparam int CNT_W = $clog2(IN_DEPTH + 1);

    acc_state_t       state, state_next;
    fp32_t            acc, add_sum, acc_next, din;
    logic [CNT_W-1:0] cnt;
    logic             exc_sticky, ovf_sticky;
    logic             add_ovf, acc_is_inf, in_exc, in_ovf, in_fire, out_fire, last_beat;

    assign din = fp32_t'(data_in_0);

    float_add_core u_add (
        .a        (acc),
        .b        (din),
        .sum      (add_sum),
        .overflow (add_ovf)
    );

    // a saturated accumulator stays at inf for the rest of the group
    assign acc_is_inf = (acc.exp == FP32_EXP_MAX);
    assign acc_next   = acc_is_inf ? acc : add_sum;
    assign in_ovf     = !acc_is_inf && add_ovf;
    assign in_exc     = data_in_0_exception || (din.exp == FP32_EXP_MAX);

    assign data_in_0_ready = (state == ACC) && !rst;
    assign in_fire   = data_in_0_valid && data_in_0_ready;
    assign out_fire  = data_out_0_valid && data_out_0_ready;
    assign last_beat = (cnt == CNT_W'(IN_DEPTH - 1));

    always_comb begin
        state_next = state;
        case (state)
            ACC:  if (in_fire && last_beat) state_next = DONE;
            DONE: if (out_fire) state_next = ACC;
            default: state_next = ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                <= ACC;
            acc                  <= FP32_POS_ZERO;
            cnt                  <= '0;
            exc_sticky           <= 1'b0;
            ovf_sticky           <= 1'b0;
            data_out_0           <= 32'd0;
            data_out_0_exception <= 1'b0;
            data_out_0_overflow  <= 1'b0;
            data_out_0_valid     <= 1'b0;
        end else begin
            state <= state_next;
            if (in_fire) begin
                acc        <= acc_next;
                exc_sticky <= exc_sticky || in_exc;
                ovf_sticky <= ovf_sticky || in_ovf;
                if (last_beat) begin
                    cnt                  <= '0;
                    data_out_0           <= acc_next;
                    data_out_0_exception <= exc_sticky || in_exc;
                    data_out_0_overflow  <= ovf_sticky || in_ovf;
                    data_out_0_valid     <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
            if (out_fire) begin
                data_out_0_valid <= 1'b0;
                acc              <= FP32_POS_ZERO;
                exc_sticky       <= 1'b0;
                ovf_sticky       <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_float_accumulator.sv
// tb/tb_float_accumulator.sv - scoreboard bench for float_accumulator at IN_DEPTH 4 and 2
module tb_float_accumulator;

    typedef struct {
        string       name;
        logic [31:0] data;
        logic        exc;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst  [2];
    logic [31:0] din  [2];
    logic        dexc [2];
    logic        dval [2];
    logic        drdy [2];
    logic [31:0] dout [2];
    logic        oexc [2];
    logic        oovf [2];
    logic        oval [2];
    logic        ordy [2];

    exp_t q0[$];
    exp_t q1[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    float_accumulator #(.IN_DEPTH(4)) u_dut4 (
        .clk(clk), .rst(rst[0]),
        .data_in_0(din[0]), .data_in_0_exception(dexc[0]),
        .data_in_0_valid(dval[0]), .data_in_0_ready(drdy[0]),
        .data_out_0(dout[0]), .data_out_0_exception(oexc[0]),
        .data_out_0_overflow(oovf[0]), .data_out_0_valid(oval[0]),
        .data_out_0_ready(ordy[0])
    );

    float_accumulator #(.IN_DEPTH(2)) u_dut2 (
        .clk(clk), .rst(rst[1]),
        .data_in_0(din[1]), .data_in_0_exception(dexc[1]),
        .data_in_0_valid(dval[1]), .data_in_0_ready(drdy[1]),
        .data_out_0(dout[1]), .data_out_0_exception(oexc[1]),
        .data_out_0_overflow(oovf[1]), .data_out_0_valid(oval[1]),
        .data_out_0_ready(ordy[1])
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    task automatic mon(input int d);
        exp_t e;
        n_vec++;
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            n_err++;
            $display("FAIL unexpected_output dut%0d: got %h, want no result", d, dout[d]);
            return;
        end
        e = (d == 0) ? q0.pop_front() : q1.pop_front();
        if (dout[d] !== e.data || oexc[d] !== e.exc || oovf[d] !== e.ovf) begin
            n_err++;
            $display("FAIL %s: got data=%h exc=%b ovf=%b, want data=%h exc=%b ovf=%b",
                     e.name, dout[d], oexc[d], oovf[d], e.data, e.exc, e.ovf);
        end
    endtask

    always @(negedge clk) if (!rst[0] && oval[0] && ordy[0]) mon(0);
    always @(negedge clk) if (!rst[1] && oval[1] && ordy[1]) mon(1);

    task automatic expect_out(input int d, input string name, input logic [31:0] data,
                              input logic e, input logic o);
        exp_t x;
        x.name = name; x.data = data; x.exc = e; x.ovf = o;
        if (d == 0) q0.push_back(x); else q1.push_back(x);
    endtask

    task automatic send(input int d, input logic [31:0] v, input logic e);
        bit ok = 1'b0;
        din[d] = v; dexc[d] = e; dval[d] = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (drdy[d]) ok = 1'b1;
        end
        if (ok) begin
            @(posedge clk); #1;
        end else begin
            n_vec++; n_err++;
            $display("FAIL send_timeout dut%0d: got ready=0, want ready=1 within 50 cycles", d);
        end
    endtask

    task automatic burst(input int d, input int n, input logic [31:0] v [4], input logic [3:0] emask);
        for (int i = 0; i < n; i++) send(d, v[i], emask[i]);
        dval[d] = 1'b0; dexc[d] = 1'b0;
    endtask

    task automatic drain(input int d);
        bit done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(posedge clk);
            if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) done = 1'b1;
        end
        #1;
        if (!done) begin
            n_vec++; n_err++;
            $display("FAIL drain_timeout dut%0d: got pending results, want none", d);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; din[d] = 32'd0; dexc[d] = 1'b0; dval[d] = 1'b0; ordy[d] = 1'b1;
        end
        @(posedge clk); @(negedge clk);
        chk("ready_in_reset", 32'(drdy[0]), 32'd0);
        @(posedge clk); #1;
        rst[0] = 1'b0; rst[1] = 1'b0;
        @(negedge clk);
        chk("reset_valid", 32'(oval[0]), 32'd0);
        chk("reset_data", dout[0], 32'd0);
        chk("reset_ready", 32'(drdy[1]), 32'd1);
        @(posedge clk); #1;

        // sum of four ones, result valid exactly one cycle after the 4th accept
        expect_out(0, "sum_4x1", 32'h4080_0000, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) send(0, 32'h3F80_0000, 1'b0);
        chk("valid_before_last", 32'(oval[0]), 32'd0);
        send(0, 32'h3F80_0000, 1'b0);
        chk("valid_after_last", 32'(oval[0]), 32'd1);
        dval[0] = 1'b0;
        drain(0);

        expect_out(0, "cancel", 32'h0000_0000, 1'b0, 1'b0);
        burst(0, 4, '{32'h3FC0_0000, 32'hBFC0_0000, 32'h3F80_0000, 32'hBF80_0000}, 4'b0000);
        drain(0);

        // backpressure: result held, no input consumed while DONE
        ordy[0] = 1'b0;
        expect_out(0, "bp_held", 32'h4080_0000, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send(0, 32'h3F80_0000, 1'b0);
        din[0] = 32'h4000_0000; dval[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(oval[0]), 32'd1);
            chk("bp_data_stable", dout[0], 32'h4080_0000);
            chk("bp_in_ready", 32'(drdy[0]), 32'd0);
        end
        @(posedge clk); #1;
        dval[0] = 1'b0; ordy[0] = 1'b1;
        drain(0);
        expect_out(0, "after_bp", 32'h4080_0000, 1'b0, 1'b0);
        burst(0, 4, '{32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000}, 4'b0000);
        drain(0);

        // reset after two beats discards the partial group
        burst(0, 2, '{32'h3F80_0000, 32'h3F80_0000, 32'h0, 32'h0}, 4'b0000);
        rst[0] = 1'b1;
        @(posedge clk); #1;
        rst[0] = 1'b0;
        expect_out(0, "after_reset", 32'h4100_0000, 1'b0, 1'b0);
        burst(0, 4, '{32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000}, 4'b0000);
        drain(0);

        expect_out(0, "exc_flag", 32'h4080_0000, 1'b1, 1'b0);
        burst(0, 4, '{32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000}, 4'b0010);
        expect_out(0, "exc_inf_input", 32'h4040_0000, 1'b1, 1'b0);
        burst(0, 4, '{32'h7F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000}, 4'b0000);
        expect_out(0, "exc_cleared", 32'h4080_0000, 1'b0, 1'b0);
        burst(0, 4, '{32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000}, 4'b0000);
        drain(0);

        // IN_DEPTH=2 instance: rounding, flush, sign handling and overflow
        expect_out(1, "round_tie_even", 32'h3F80_0000, 1'b0, 1'b0);
        burst(1, 2, '{32'h3F80_0000, 32'h3380_0000, 32'h0, 32'h0}, 4'b0000);
        expect_out(1, "round_lsb", 32'h3F80_0001, 1'b0, 1'b0);
        burst(1, 2, '{32'h3F80_0000, 32'h3400_0000, 32'h0, 32'h0}, 4'b0000);
        expect_out(1, "round_tie_odd_up", 32'h3F80_0002, 1'b0, 1'b0);
        burst(1, 2, '{32'h3F80_0001, 32'h3380_0000, 32'h0, 32'h0}, 4'b0000);
        expect_out(1, "subnormal_flush", 32'h3F80_0000, 1'b0, 1'b0);
        burst(1, 2, '{32'h0000_0001, 32'h3F80_0000, 32'h0, 32'h0}, 4'b0000);
        expect_out(1, "neg_sub", 32'hBF00_0000, 1'b0, 1'b0);
        burst(1, 2, '{32'hBF80_0000, 32'h3F00_0000, 32'h0, 32'h0}, 4'b0000);
        expect_out(1, "overflow_sat", 32'h7F80_0000, 1'b0, 1'b1);
        burst(1, 2, '{32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h0, 32'h0}, 4'b0000);
        expect_out(1, "after_overflow", 32'h4000_0000, 1'b0, 1'b0);
        burst(1, 2, '{32'h3F80_0000, 32'h3F80_0000, 32'h0, 32'h0}, 4'b0000);
        drain(1);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
